// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: NREQ requesters compete for a single register-file write port through one output stage.
// Define RR_ARB_EN for round-robin arbitration; otherwise fixed priority applies and the lowest index wins.
module regfile_wb_arbiter #(
    parameter int NREQ    = 3,
    parameter int A_WIDTH = 5,
    parameter int D_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*A_WIDTH-1:0] req_addr,
    input  logic [NREQ*D_WIDTH-1:0] req_data,
    input  logic                    rf_stall,
    output logic                    rf_we,
    output logic [A_WIDTH-1:0]      rf_waddr,
    output logic [D_WIDTH-1:0]      rf_wdata,
    output logic [2**A_WIDTH-1:0]   rf_pend
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic               out_valid;
    logic [A_WIDTH-1:0] out_addr;
    logic [D_WIDTH-1:0] out_data;

    logic               stage_free;
    logic               gnt_any;
    logic [IDX_W-1:0]   gnt_idx;
    logic [NREQ-1:0]    gnt_vec;
    logic               xfer;
    logic [A_WIDTH-1:0] sel_addr;
    logic [D_WIDTH-1:0] sel_data;

    // A held write that commits this edge frees the stage, so it can drain and refill in one cycle.
    assign stage_free = !out_valid || !rf_stall;

`ifdef RR_ARB_EN
    logic [IDX_W-1:0] ptr;

    always_comb begin
        int idx;
        // NOTE: every output gets a default first, so no path leaves it unassigned and no latch is inferred.
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (xfer) begin
            ptr <= (gnt_idx == IDX_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end
`else
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_any && req_valid[k]) begin
                gnt_any = 1'b1;
                gnt_idx = IDX_W'(k);
            end
        end
    end
`endif

    // Ready is gated by reset so no handshake can complete while the block is held in reset.
    always_comb begin
        gnt_vec = '0;
        if (rst && stage_free && gnt_any) begin
            gnt_vec[gnt_idx] = 1'b1;
        end
    end

    assign req_ready = gnt_vec;
    assign xfer      = |gnt_vec;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (IDX_W'(k) == gnt_idx) begin
                sel_addr = req_addr[k*A_WIDTH +: A_WIDTH];
                sel_data = req_data[k*D_WIDTH +: D_WIDTH];
            end
        end
    end

    // A write to x0 is consumed but leaves the stage empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else if (xfer) begin
            out_valid <= (sel_addr != '0);
            out_addr  <= sel_addr;
            out_data  <= sel_data;
        end else if (stage_free) begin
            out_valid <= 1'b0;
        end
    end

    assign rf_we    = out_valid;
    assign rf_waddr = out_addr;
    assign rf_wdata = out_data;

    always_comb begin
        rf_pend = '0;
        if (out_valid) begin
            rf_pend[out_addr] = 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: stimulus queues expected grants and writes; a negedge monitor checks them.
module tb_regfile_wb_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic                 rf_stall;
    logic                 rf_we;
    logic [AW-1:0]        rf_waddr;
    logic [DW-1:0]        rf_wdata;
    logic [2**AW-1:0]     rf_pend;

    int checks = 0;
    int errors = 0;

    int               gnt_q[$];
    logic [AW+DW-1:0] wr_q[$];

    regfile_wb_arbiter #(.NREQ(NREQ), .A_WIDTH(AW), .D_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .rf_stall(rf_stall),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_pend(rf_pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] wdat(input int g, input int k);
        return 32'h1000_0000 * (g + 1) + DW'(k);
    endfunction

    // Monitor: every grant and every committing write must match the head of its queue.
    always @(negedge clk) begin
        if (req_ready != '0) begin
            if (gnt_q.size() == 0) begin
                check("unexpected_grant", 64'(req_ready), 64'd0);
            end else begin
                int g;
                g = gnt_q.pop_front();
                check("grant", 64'(req_ready), 64'd1 << g);
            end
        end
        if (rf_we && !rf_stall) begin
            if (wr_q.size() == 0) begin
                check("unexpected_write", {27'd0, rf_waddr, rf_wdata}, 64'd0);
            end else begin
                logic [AW+DW-1:0] e;
                e = wr_q.pop_front();
                check("write", {27'd0, rf_waddr, rf_wdata}, {27'd0, e});
                check("write_pend", 64'(rf_pend), 64'd1 << e[AW+DW-1:DW]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int exp_g[6];
        int cnt[NREQ];
`ifdef RR_ARB_EN
        exp_g = '{0, 1, 2, 0, 1, 2};
`else
        exp_g = '{0, 0, 0, 0, 0, 0};
`endif
        rst       = 1'b0;
        rf_stall  = 1'b0;
        req_valid = '1;
        req_addr  = '0;
        req_data  = '0;
        req_addr[0*AW +: AW] = 5'd4;

        // Reset state with all requesters active.
        @(negedge clk);
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_we", 64'(rf_we), 64'd0);
        check("rst_waddr", 64'(rf_waddr), 64'd0);
        check("rst_wdata", 64'(rf_wdata), 64'd0);
        check("rst_pend", 64'(rf_pend), 64'd0);

        // Single write from requester 0.
        tick();
        rst       = 1'b1;
        req_valid = 3'b001;
        req_addr[0*AW +: AW] = 5'd5;
        req_data[0*DW +: DW] = 32'hDEAD_BEEF;
        gnt_q.push_back(0);
        wr_q.push_back({5'd5, 32'hDEAD_BEEF});
        tick();
        req_valid = '0;
        @(negedge clk);
        check("single_we", 64'(rf_we), 64'd1);
        check("single_pend", 64'(rf_pend), 64'd1 << 5);

        // Write to x0 is consumed without a register-file write.
        tick();
        req_valid = 3'b010;
        req_addr[1*AW +: AW] = 5'd0;
        req_data[1*DW +: DW] = 32'h0000_1234;
        gnt_q.push_back(1);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("x0_we", 64'(rf_we), 64'd0);
        check("x0_pend", 64'(rf_pend), 64'd0);

        // Fresh reset, then all three requesters stay valid for six grants.
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            cnt[i] = 0;
            req_addr[i*AW +: AW] = AW'(10 + i);
            req_data[i*DW +: DW] = wdat(i, 0);
        end
        req_valid = '1;
        for (int c = 0; c < 6; c++) begin
            int g;
            g = exp_g[c];
            gnt_q.push_back(g);
            wr_q.push_back({AW'(10 + g), wdat(g, cnt[g])});
            tick();
            cnt[g]++;
            req_data[g*DW +: DW] = wdat(g, cnt[g]);
        end
        req_valid = '0;
        tick();
        tick();

        // Stall holds the stage and blocks grants; grant resumes as the held write commits.
        req_valid = 3'b001;
        req_addr[0*AW +: AW] = 5'd7;
        req_data[0*DW +: DW] = 32'hA5A5_A5A5;
        gnt_q.push_back(0);
        wr_q.push_back({5'd7, 32'hA5A5_A5A5});
        tick();
        req_valid = 3'b100;
        req_addr[2*AW +: AW] = 5'd3;
        req_data[2*DW +: DW] = 32'h0000_0033;
        rf_stall  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall_we", 64'(rf_we), 64'd1);
            check("stall_waddr", 64'(rf_waddr), 64'd7);
            check("stall_wdata", 64'(rf_wdata), 64'hA5A5_A5A5);
            check("stall_ready", 64'(req_ready), 64'd0);
            tick();
        end
        rf_stall = 1'b0;
        gnt_q.push_back(2);
        wr_q.push_back({5'd3, 32'h0000_0033});
        tick();
        req_valid = '0;
        @(negedge clk);
        check("post_stall_pend", 64'(rf_pend), 64'd1 << 3);
        tick();

        // Reset during a stall discards the held write without committing it.
        req_valid = 3'b010;
        req_addr[1*AW +: AW] = 5'd9;
        req_data[1*DW +: DW] = 32'h0000_0099;
        gnt_q.push_back(1);
        tick();
        req_valid = '0;
        rf_stall  = 1'b1;
        @(negedge clk);
        check("held_we", 64'(rf_we), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_we", 64'(rf_we), 64'd0);
        check("async_rst_pend", 64'(rf_pend), 64'd0);
        check("async_rst_waddr", 64'(rf_waddr), 64'd0);
        tick();
        rf_stall = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("after_rst_we", 64'(rf_we), 64'd0);

        tick();
        check("grants_left", 64'(gnt_q.size()), 64'd0);
        check("writes_left", 64'(wr_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
